// File: rtl/spi_rx_deframer.sv
// SPI mode-0 slave front end: synchronises SCK/CS_n/MOSI and deframes status/address/data words.
// Optional PARTIAL_WORD_ERR_EN adds a partial_err pulse on mid-field chip-select aborts.
module spi_rx_deframer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sck,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        status_ready,
    output logic        address_ready,
    output logic        data_ready,
    output logic [3:0]  status,
    output logic [19:0] addr,
    output logic [15:0] wdata,
    output logic        cs_n_o,
`ifdef PARTIAL_WORD_ERR_EN
    output logic        partial_err,
`endif
    output logic        miso_start
);

    localparam int unsigned STATUS_W = 4;
    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STATUS,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_q;
    logic                   sck_s, cs_s, mosi_s, sck_rise;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-2:0] shift, shift_n;
    logic [ADDR_W-1:0] bit_word;
    logic              status_ready_n, address_ready_n, data_ready_n, miso_start_n;
    logic [3:0]        status_n;
    logic [19:0]       addr_n;
    logic [15:0]       wdata_n;
`ifdef PARTIAL_WORD_ERR_EN
    logic              partial_err_n;
`endif

    // Pin synchronisers; cs_n idles high so reset does not look like a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_q     <= sck_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign bit_word = {shift, mosi_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            shift         <= '0;
            status_ready  <= 1'b0;
            address_ready <= 1'b0;
            data_ready    <= 1'b0;
            miso_start    <= 1'b0;
            status        <= '0;
            addr          <= '0;
            wdata         <= '0;
            cs_n_o        <= 1'b1;
`ifdef PARTIAL_WORD_ERR_EN
            partial_err   <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            shift         <= shift_n;
            status_ready  <= status_ready_n;
            address_ready <= address_ready_n;
            data_ready    <= data_ready_n;
            miso_start    <= miso_start_n;
            status        <= status_n;
            addr          <= addr_n;
            wdata         <= wdata_n;
            cs_n_o        <= cs_s;
`ifdef PARTIAL_WORD_ERR_EN
            partial_err   <= partial_err_n;
`endif
        end
    end

    // Deframing FSM; a high chip select overrides any simultaneous SCK edge.
    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        shift_n         = shift;
        status_n        = status;
        addr_n          = addr;
        wdata_n         = wdata;
        status_ready_n  = 1'b0;
        address_ready_n = 1'b0;
        data_ready_n    = 1'b0;
        miso_start_n    = 1'b0;
`ifdef PARTIAL_WORD_ERR_EN
        partial_err_n   = 1'b0;
`endif
        if (cs_s) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
`ifdef PARTIAL_WORD_ERR_EN
            partial_err_n = (state == ST_STATUS || state == ST_ADDR || state == ST_DATA)
                            && (cnt != '0);
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_STATUS;
                    cnt_n   = '0;
                end
                ST_STATUS: begin
                    if (sck_rise) begin
                        shift_n = bit_word[ADDR_W-2:0];
                        if (cnt == CNT_W'(STATUS_W - 1)) begin
                            status_n       = bit_word[STATUS_W-1:0];
                            status_ready_n = 1'b1;
                            cnt_n          = '0;
                            state_n        = ST_ADDR;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        shift_n = bit_word[ADDR_W-2:0];
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            addr_n          = bit_word;
                            address_ready_n = 1'b1;
                            cnt_n           = '0;
                            state_n         = ST_DATA;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        shift_n      = bit_word[ADDR_W-2:0];
                        miso_start_n = (cnt == '0) && !status[2];
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            wdata_n      = bit_word[DATA_W-1:0];
                            data_ready_n = 1'b1;
                            cnt_n        = '0;
                            state_n      = status[1] ? ST_DATA : ST_DRAIN;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    state_n = ST_DRAIN;
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx_deframer.sv
// Scoreboard bench for spi_rx_deframer: directed SPI frames, expected events queued, monitor compares.
module tb_spi_rx_deframer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        status_ready, address_ready, data_ready, cs_n_o, miso_start;
    logic [3:0]  status;
    logic [19:0] addr;
    logic [15:0] wdata;
`ifdef PARTIAL_WORD_ERR_EN
    logic        partial_err;
`endif

    spi_rx_deframer #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sck           (sck),
        .cs_n          (cs_n),
        .mosi          (mosi),
        .status_ready  (status_ready),
        .address_ready (address_ready),
        .data_ready    (data_ready),
        .status        (status),
        .addr          (addr),
        .wdata         (wdata),
        .cs_n_o        (cs_n_o),
`ifdef PARTIAL_WORD_ERR_EN
        .partial_err   (partial_err),
`endif
        .miso_start    (miso_start)
    );

    always #5 clk = ~clk;

    localparam int K_STATUS = 0, K_ADDR = 1, K_DATA = 2, K_MISO = 3, K_PERR = 4;
    typedef struct {
        int          kind;
        logic [19:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  data_t[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  prev_stb = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int k, input logic [19:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k, input logic [19:0] v);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: unexpected kind=%0d val=%h, none required", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                fails++;
                $display("FAIL event: got kind=%0d val=%h, required kind=%0d val=%h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output pulse and polices strobe spacing.
    always @(negedge clk) begin
        int nstb;
        if (reset_n) begin
            nstb = int'(status_ready) + int'(address_ready) + int'(data_ready);
            if (nstb > 0) begin
                tests++;
                if (nstb > 1 || prev_stb) begin
                    fails++;
                    $display("FAIL strobe_excl: %0d strobes, prev=%0d, required single isolated",
                             nstb, prev_stb);
                end
            end
            prev_stb = (nstb > 0);
            if (status_ready)  check_ev(K_STATUS, 20'(status));
            if (address_ready) check_ev(K_ADDR, addr);
            if (data_ready) begin
                check_ev(K_DATA, 20'(wdata));
                data_t.push_back(cyc);
            end
            if (miso_start)    check_ev(K_MISO, 20'd0);
`ifdef PARTIAL_WORD_ERR_EN
            if (partial_err)   check_ev(K_PERR, 20'd0);
`endif
        end else begin
            prev_stb = 0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        wait_clk(8);
        sck = 1'b1;
        wait_clk(8);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [19:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic cs_low();
        wait_clk(2);
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(16);
    endtask

    task automatic push_perr();
`ifdef PARTIAL_WORD_ERR_EN
        push(K_PERR, 20'd0);
`endif
    endtask

    initial begin
        logic [15:0] race_word;
        wait_clk(4);
        chk("rst_status_ready", 20'(status_ready), 20'd0);
        chk("rst_address_ready", 20'(address_ready), 20'd0);
        chk("rst_data_ready", 20'(data_ready), 20'd0);
        chk("rst_miso_start", 20'(miso_start), 20'd0);
        chk("rst_status", 20'(status), 20'd0);
        chk("rst_addr", addr, 20'd0);
        chk("rst_wdata", 20'(wdata), 20'd0);
        chk("rst_cs_n_o", 20'(cs_n_o), 20'd1);
        reset_n = 1'b1;
        wait_clk(4);

        // Single write
        push(K_STATUS, 20'h4); push(K_ADDR, 20'h01234); push(K_DATA, 20'hBEEF);
        cs_low();
        chk("cs_n_o_low", 20'(cs_n_o), 20'd0);
        send_bits(20'h4, 4); send_bits(20'h01234, 20); send_bits(20'hBEEF, 16);
        cs_high();
        chk("cs_n_o_high", 20'(cs_n_o), 20'd1);

        // Burst write, three words 256 clk apart
        data_t.delete();
        push(K_STATUS, 20'h6); push(K_ADDR, 20'h00100);
        push(K_DATA, 20'h1111); push(K_DATA, 20'h2222); push(K_DATA, 20'h3333);
        cs_low();
        send_bits(20'h6, 4); send_bits(20'h00100, 20);
        send_bits(20'h1111, 16); send_bits(20'h2222, 16); send_bits(20'h3333, 16);
        cs_high();
        chk("burst_count", 20'(data_t.size()), 20'd3);
        if (data_t.size() == 3) begin
            chk("burst_gap1", 20'(data_t[1] - data_t[0]), 20'd256);
            chk("burst_gap2", 20'(data_t[2] - data_t[1]), 20'd256);
        end

        // Single read, then extra bits are drained
        push(K_STATUS, 20'h1); push(K_ADDR, 20'h00010);
        push(K_MISO, 20'd0); push(K_DATA, 20'hA5A5);
        cs_low();
        send_bits(20'h1, 4); send_bits(20'h00010, 20); send_bits(20'hA5A5, 16);
        send_bits(20'h5A5A, 16);
        cs_high();

        // Abort after 10 address bits
        push(K_STATUS, 20'h4); push_perr();
        cs_low();
        send_bits(20'h4, 4); send_bits(20'h3FF, 10);
        cs_high();
        chk("abort_addr_held", addr, 20'h00010);

        // CS rises with the 16th data edge; next frame normal
        push(K_STATUS, 20'h4); push(K_ADDR, 20'h0ABCD); push_perr();
        cs_low();
        send_bits(20'h4, 4); send_bits(20'h0ABCD, 20);
        race_word = 16'h1234;
        for (int i = 15; i >= 1; i--) send_bit(race_word[i]);
        mosi = race_word[0];
        wait_clk(8);
        sck  = 1'b1;
        cs_n = 1'b1;
        wait_clk(8);
        sck  = 1'b0;
        wait_clk(16);
        chk("race_wdata_held", 20'(wdata), 20'hA5A5);
        push(K_STATUS, 20'h4); push(K_ADDR, 20'h00055); push(K_DATA, 20'h5678);
        cs_low();
        send_bits(20'h4, 4); send_bits(20'h00055, 20); send_bits(20'h5678, 16);
        cs_high();

        // Async reset mid-burst
        push(K_STATUS, 20'h6); push(K_ADDR, 20'h00200); push(K_DATA, 20'h9999);
        cs_low();
        send_bits(20'h6, 4); send_bits(20'h00200, 20); send_bits(20'h9999, 16);
        send_bits(20'h15, 5);
        wait_clk(1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_status", 20'(status), 20'd0);
        chk("mid_rst_addr", addr, 20'd0);
        chk("mid_rst_wdata", 20'(wdata), 20'd0);
        chk("mid_rst_cs_n_o", 20'(cs_n_o), 20'd1);
        chk("mid_rst_strobes", 20'({status_ready, address_ready, data_ready, miso_start}), 20'd0);
        cs_n = 1'b1;
        sck  = 1'b0;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(4);
        push(K_STATUS, 20'h4); push(K_ADDR, 20'h00321); push(K_DATA, 20'hCAFE);
        cs_low();
        send_bits(20'h4, 4); send_bits(20'h00321, 20); send_bits(20'hCAFE, 16);
        cs_high();

        wait_clk(20);
        chk("scoreboard_empty", 20'(exp_q.size()), 20'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
